// File: rtl/ext_mem_arbiter_pkg.sv
// Shared definitions for the external TCM arbiter and the FPGA top.
// Holds the default TCM geometry, the per-port request bundle and a width helper.
package ext_mem_arbiter_pkg;

    // TCM geometry shared by the FPGA top and the arbiter defaults.
    localparam int unsigned EXT_MEM_BYTES = 32'h0002_0000;
    localparam int unsigned EXT_MEM_BASE  = 32'h0000_1000;
    localparam int unsigned EXT_MEM_DW    = 32;
    localparam int unsigned EXT_MEM_AW    = 32;

    // One requester's access bundle as seen by the FPGA top.
    typedef struct packed {
        logic                    we;
        logic [EXT_MEM_DW/8-1:0] be;
        logic [EXT_MEM_AW-1:0]   addr;
        logic [EXT_MEM_DW-1:0]   wdata;
    } ext_mem_req_t;

    // Wait-counter width; kept at least one bit so MAX_WAIT=0 still elaborates.
    function automatic int unsigned wait_cnt_width(input int unsigned max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/ext_mem_arb_aging.sv
// Port-1 aging for the external TCM arbiter, used only when EXT_MEM_ARB_AGING_EN is defined.
// Counts cycles in which port 1 requests but is denied; when the count reaches
// MAX_WAIT, port 1 takes priority over port 0 for one grant.
module ext_mem_arb_aging
    import ext_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8,
    localparam int unsigned CNT_WIDTH = wait_cnt_width(MAX_WAIT)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic gnt_i,
    output logic prio_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 cnt_sat;

    assign cnt_sat = (cnt_q == CNT_WIDTH'(MAX_WAIT));

    // Next count: clear on grant or idle, otherwise count denied cycles up to saturation.
    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || gnt_i) begin
            cnt_d = '0;
        end else if (!cnt_sat) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Wait counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Override depends only on registered state, so there is no loop through gnt_i.
    assign prio_o = req_i && cnt_sat;

endmodule

// File: rtl/ext_mem_arbiter.sv
// Two-port arbiter and sequencer for the single-port external TCM.
// Port 0 (AXI path) has fixed priority; port 1 (debug/DMA) may starve unless
// EXT_MEM_ARB_AGING_EN is defined, which adds a bounded-wait override for port 1.
// Grant is combinational; the response (rvalid) follows one cycle after the grant
// and read data passes straight through from the TCM.
module ext_mem_arbiter
    import ext_mem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_BYTES  = EXT_MEM_BYTES,
    parameter int unsigned BASE_ADDR  = EXT_MEM_BASE,
    parameter int unsigned MAX_WAIT   = 8,
    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8,
    localparam int unsigned MEM_AW    = $clog2(MEM_BYTES)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [1:0]                          req_i,
    input  logic [1:0]                          we_i,
    input  logic [1:0][BE_WIDTH-1:0]            be_i,
    input  logic [1:0][ADDR_WIDTH-1:0]          addr_i,
    input  logic [1:0][DATA_WIDTH-1:0]          wdata_i,
    output logic [1:0]                          gnt_o,
    output logic [1:0]                          rvalid_o,
    output logic [DATA_WIDTH-1:0]               rdata_o,
    output logic                                mem_en_o,
    output logic                                mem_we_o,
    output logic [BE_WIDTH-1:0]                 mem_be_o,
    output logic [MEM_AW-1:0]                   mem_addr_o,
    output logic [DATA_WIDTH-1:0]               mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]               mem_rdata_i
);

    logic                  prio1;
    logic [1:0]            gnt;
    logic                  sel;
    logic [ADDR_WIDTH-1:0] addr_diff;
    logic                  rsp_vld_q, rsp_vld_d;
    logic                  rsp_port_q, rsp_port_d;

`ifdef EXT_MEM_ARB_AGING_EN
    ext_mem_arb_aging #(
        .MAX_WAIT (MAX_WAIT)
    ) u_aging (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_i[1]),
        .gnt_i  (gnt[1]),
        .prio_o (prio1)
    );
`else
    // Strict priority: port 1 never overrides port 0.
    logic unused_max_wait;
    assign unused_max_wait = ^MAX_WAIT;
    assign prio1           = 1'b0;
`endif

    // Grant selection; nothing is granted while reset is held so no access is lost.
    always_comb begin
        gnt = 2'b00;
        if (rst_ni) begin
            if (req_i[1] && (prio1 || !req_i[0])) begin
                gnt = 2'b10;
            end else if (req_i[0]) begin
                gnt = 2'b01;
            end
        end
    end

    assign gnt_o = gnt;
    assign sel   = gnt[1];

    // Rebase onto the TCM; wrap-around by truncation is intentional (no range check).
    assign addr_diff = addr_i[sel] - ADDR_WIDTH'(BASE_ADDR);

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_diff[ADDR_WIDTH-1:MEM_AW];

    // Memory-side mux; all outputs held at zero when no grant is given.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (|gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = we_i[sel];
            mem_be_o    = be_i[sel];
            mem_addr_o  = addr_diff[MEM_AW-1:0];
            mem_wdata_o = wdata_i[sel];
        end
    end

    // Next-state of the response tracker: remember whether and to whom we granted.
    always_comb begin
        rsp_vld_d  = |gnt;
        rsp_port_d = gnt[1];
    end

    // Response tracking registers; async reset drops any pending response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_vld_q  <= 1'b0;
            rsp_port_q <= 1'b0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            rsp_port_q <= rsp_port_d;
        end
    end

    assign rvalid_o[0] = rsp_vld_q && !rsp_port_q;
    assign rvalid_o[1] = rsp_vld_q &&  rsp_port_q;
    assign rdata_o     = mem_rdata_i;

endmodule
